// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared constants, FSM states and hex glyph decode for seg_scan_capture.
package seg_scan_pkg;
  localparam int NUM_DIGITS = 8;
  localparam int SEG_W = 8;
  typedef enum logic {WAIT, HELD} state_t;
  // Active-high {g,f,e,d,c,b,a} glyphs; entry n is the pattern for hex digit n.
  localparam logic [15:0][6:0] GLYPHS = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  function automatic logic [4:0] hex_decode(input logic [6:0] pat);
    hex_decode = '0;
    for (int i = 0; i < 16; i++)
      if (pat == GLYPHS[i]) hex_decode = {1'b1, 4'(i)};
  endfunction
endpackage

// File: rtl/seg_scan_capture_an_dec.sv
// an_onehot_dec: classifies an active-low anode word as single digit, blank or multi-select.
module an_onehot_dec
  import seg_scan_pkg::*;
(
  input  logic [NUM_DIGITS-1:0] i_an,
  output logic [2:0]            o_idx,
  output logic                  o_one_hot,
  output logic                  o_blank,
  output logic                  o_multi
);
  logic [NUM_DIGITS-1:0] w_low;
  assign w_low     = ~i_an;
  assign o_blank   = w_low == '0;
  assign o_one_hot = !o_blank && (w_low & (w_low - NUM_DIGITS'(1))) == '0;
  assign o_multi   = !o_blank && !o_one_hot;
  always_comb begin
    o_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (w_low[i]) o_idx = 3'(i);
  end
endmodule

// File: rtl/seg_scan_capture.sv
// seg_scan_capture: samples a multiplexed 7-seg scan and rebuilds the eight digit patterns.
// Define SEG_SCAN_CAPTURE_HEXDEC_EN to add per-digit hex decode outputs.
module seg_scan_capture
  import seg_scan_pkg::*;
#(
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_DIGITS-1:0]       an_i,
  input  logic [SEG_W-1:0]            seg_i,
  output logic [NUM_DIGITS*SEG_W-1:0] digits_o,
  output logic [NUM_DIGITS-1:0]       seen_o,
  output logic                        frame_o,
  output logic                        err_o
`ifdef SEG_SCAN_CAPTURE_HEXDEC_EN
  ,
  output logic [NUM_DIGITS*4-1:0]     hex_o,
  output logic [NUM_DIGITS-1:0]       hex_valid_o
`endif
);
  logic [NUM_DIGITS-1:0] r_an_s1, r_an_s2;
  logic [SEG_W-1:0]      r_seg_s1, r_seg_s2;
  logic [CNT_W-1:0]      r_cnt;
  state_t                r_state;
  logic [2:0]            w_idx;
  logic                  w_one_hot, w_blank, w_multi, w_chg, w_fire, w_wr;
  an_onehot_dec u_dec (
    .i_an      (r_an_s2),
    .o_idx     (w_idx),
    .o_one_hot (w_one_hot),
    .o_blank   (w_blank),
    .o_multi   (w_multi)
  );
  // The second sync stage about to change is the same as it differing from last cycle.
  assign w_chg  = {r_an_s1, r_seg_s1} != {r_an_s2, r_seg_s2};
  assign w_fire = r_state == WAIT && r_cnt == CNT_W'(STABLE_CYCLES);
  assign w_wr   = w_fire && w_one_hot;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an_s1  <= '1;
      r_an_s2  <= '1;
      r_seg_s1 <= '1;
      r_seg_s2 <= '1;
    end else begin
      r_an_s1  <= an_i;
      r_an_s2  <= r_an_s1;
      r_seg_s1 <= seg_i;
      r_seg_s2 <= r_seg_s1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cnt <= '0;
    else if (w_chg) r_cnt <= '0;
    else if (r_cnt != CNT_W'(STABLE_CYCLES)) r_cnt <= r_cnt + CNT_W'(1);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= WAIT;
      digits_o <= '0;
      seen_o   <= '0;
      frame_o  <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      r_state <= w_chg ? WAIT : w_fire ? HELD : r_state;
      frame_o <= seen_o == '1;
      err_o   <= w_fire && w_multi;
      seen_o  <= (seen_o == '1 ? '0 : seen_o) | (w_wr ? NUM_DIGITS'(1) << w_idx : '0);
      if (w_wr) digits_o[{w_idx, 3'b000} +: SEG_W] <= ~r_seg_s2;
    end
  end
`ifdef SEG_SCAN_CAPTURE_HEXDEC_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hex_o       <= '0;
      hex_valid_o <= '0;
    end else if (w_wr) begin
      {hex_valid_o[w_idx], hex_o[{w_idx, 2'b00} +: 4]} <= hex_decode(~r_seg_s2[6:0]);
    end
  end
`endif
endmodule

// File: tb/tb_seg_scan_capture.sv
// tb_seg_scan_capture: randomized scan stimulus checked every cycle against a behavioural model.
module tb_seg_scan_capture;
  localparam int STABLE = 16;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  an_i = 8'hFF;
  logic [7:0]  seg_i = 8'hFF;
  logic [63:0] digits_o;
  logic [7:0]  seen_o;
  logic        frame_o, err_o;
`ifdef SEG_SCAN_CAPTURE_HEXDEC_EN
  logic [31:0] hex_o;
  logic [7:0]  hex_valid_o;
`endif
  seg_scan_capture #(.STABLE_CYCLES(STABLE), .CNT_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .an_i     (an_i),
    .seg_i    (seg_i),
    .digits_o (digits_o),
    .seen_o   (seen_o),
    .frame_o  (frame_o),
    .err_o    (err_o)
`ifdef SEG_SCAN_CAPTURE_HEXDEC_EN
    ,
    .hex_o       (hex_o),
    .hex_valid_o (hex_valid_o)
`endif
  );
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int frames = 0;
  int errs = 0;
  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model: the history of applied {an,seg} words since reset, preceded by two all-ones
  // words standing in for the synchronizer. A word is captured exactly once, at the
  // edge where it has been applied for STABLE+1 consecutive edges one cycle earlier.
  logic [15:0] hist [$];
  logic [7:0]  m_dig [8];
  logic [3:0]  m_hex [8];
  logic [7:0]  m_seen, m_hv;
  logic        m_frame, m_err;
  logic [15:0] m_v;
  int          m_run, m_k;
  always @(posedge clk) begin
    if (rst) begin
      hist = {16'hFFFF, 16'hFFFF};
      m_seen = '0; m_hv = '0; m_frame = 1'b0; m_err = 1'b0;
      for (int i = 0; i < 8; i++) begin m_dig[i] = '0; m_hex[i] = '0; end
    end else begin
      m_v = hist[hist.size()-2];
      m_run = 1;
      for (int i = hist.size() - 3; i >= 0; i--) begin
        if (hist[i] != m_v || m_run > STABLE + 1) break;
        m_run++;
      end
      m_frame = m_seen == 8'hFF;
      if (m_frame) m_seen = '0;
      m_err = 1'b0;
      if (m_run == STABLE + 1) begin
        if ($countones(~m_v[15:8]) == 1) begin
          for (int i = 0; i < 8; i++) if (!m_v[8+i]) m_k = i;
          m_dig[m_k] = ~m_v[7:0];
          m_seen[m_k] = 1'b1;
          m_hv[m_k] = 1'b0; m_hex[m_k] = '0;
          for (int g = 0; g < 16; g++)
            if (glyph[g] == ~m_v[6:0]) begin m_hv[m_k] = 1'b1; m_hex[m_k] = 4'(g); end
        end else if ($countones(~m_v[15:8]) > 1) m_err = 1'b1;
      end
      hist.push_back({an_i, seg_i});
      if (hist.size() > 32) void'(hist.pop_front());
    end
  end

  logic [63:0] exp_dig;
  logic [31:0] exp_hex;
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        exp_dig[8*i +: 8] = m_dig[i];
        exp_hex[4*i +: 4] = m_hex[i];
      end
      check("digits_o", digits_o, exp_dig);
      check("seen_o", 64'(seen_o), 64'(m_seen));
      check("frame_o", 64'(frame_o), 64'(m_frame));
      check("err_o", 64'(err_o), 64'(m_err));
`ifdef SEG_SCAN_CAPTURE_HEXDEC_EN
      check("hex_o", 64'(hex_o), 64'(exp_hex));
      check("hex_valid_o", 64'(hex_valid_o), 64'(m_hv));
`endif
      frames += int'(frame_o);
      errs += int'(err_o);
    end
  end

  task automatic hold(input logic [7:0] a, input logic [7:0] s, input int n);
    an_i = a;
    seg_i = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input int first, input int last, input logic [7:0] base);
    for (int k = first; k <= last; k++) hold(~(8'(1) << k), ~(base + 8'(k)), 20);
  endtask

  logic [63:0] scan_flat;
  logic [7:0]  r_a, r_s;
  int          r_sel;
  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    frames = 0; errs = 0;
    hold(8'hFF, 8'hFF, 1000);
    check("idle_frames", 64'(frames), 64'd0);
    check("idle_errs", 64'(errs), 64'd0);
    check("idle_digits", digits_o, 64'd0);
    check("idle_seen", 64'(seen_o), 64'd0);

    frames = 0;
    scan(0, 7, 8'h06);
    hold(8'hFF, 8'hFF, 30);
    for (int k = 0; k < 8; k++) scan_flat[8*k +: 8] = 8'h06 + 8'(k);
    check("scan_digits", digits_o, 64'h0D0C_0B0A_0908_0706);
    check("scan_frames", 64'(frames), 64'd1);
    check("scan_seen", 64'(seen_o), 64'd0);

    hold(8'hFE, 8'h80, 5);
    hold(8'hFF, 8'hFF, 30);
    check("glitch_seen", 64'(seen_o), 64'd0);
    check("glitch_digits", digits_o, scan_flat);

    errs = 0;
    hold(8'hFC, 8'h00, 20);
    hold(8'hFF, 8'hFF, 30);
    check("multi_errs", 64'(errs), 64'd1);
    check("multi_seen", 64'(seen_o), 64'd0);
    check("multi_digits", digits_o, scan_flat);

`ifdef SEG_SCAN_CAPTURE_HEXDEC_EN
    hold(8'hFB, ~8'h3F, 20);
    check("hex_zero_nib", 64'(hex_o[11:8]), 64'd0);
    check("hex_zero_vld", 64'(hex_valid_o[2]), 64'd1);
    hold(8'hFB, ~8'h49, 20);
    check("hex_bad_vld", 64'(hex_valid_o[2]), 64'd0);
`endif

    for (int n = 0; n < 150; n++) begin
      r_sel = $urandom_range(0, 9);
      r_a = r_sel < 7 ? ~(8'(1) << $urandom_range(0, 7)) : r_sel < 8 ? 8'hFF : 8'($urandom);
      r_s = $urandom_range(0, 1) ? ~{1'($urandom), glyph[$urandom_range(0, 15)]} : 8'($urandom);
      hold(r_a, r_s, $urandom_range(2, 40));
    end

    hold(8'hFF, 8'hFF, 30);
    scan(0, 3, 8'hA0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_digits", digits_o, 64'd0);
    check("rst_seen", 64'(seen_o), 64'd0);
    check("rst_frame", 64'(frame_o), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    frames = 0;
    scan(4, 7, 8'hA0);
    hold(8'hFF, 8'hFF, 30);
    check("partial_frames", 64'(frames), 64'd0);
    check("partial_seen", 64'(seen_o), 64'hF0);
    check("partial_low", 64'(digits_o[31:0]), 64'd0);
    frames = 0;
    scan(0, 7, 8'h30);
    hold(8'hFF, 8'hFF, 30);
    check("rescan_frames", 64'(frames), 64'd1);
    check("rescan_digits", digits_o, 64'h3736_3534_3332_3130);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
